// File: rtl/tlut_pkg.sv
// Shared definitions for the tLUT temporal-coding datapath: decoder FSM states
// and the observation-window length that encoder and decoder must agree on.
package tlut_pkg;

   typedef enum logic [1:0] {DEC_IDLE, DEC_COUNT, DEC_HOLD} dec_state_t;

   // A DATA_WIDTH-bit value v is sent as v high cycles out of 2^DATA_WIDTH - 1.
   function automatic int window_len(input int data_width);
      return (1 << data_width) - 1;
   endfunction

endpackage

// File: rtl/temporal_decoder_if.sv
// Stream-in / result-out signal bundle of the temporal decoder.
interface temporal_decoder_if #(
   parameter int DATA_WIDTH = 4
);

   logic                  start;
   logic                  in_bit;
   logic                  busy;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_err;

   modport master (
      input  start, in_bit, out_ready,
      output busy, out_valid, out_data, out_err
   );

   modport slave (
      output start, in_bit, out_ready,
      input  busy, out_valid, out_data, out_err
   );

endinterface

// File: rtl/tlut_window_counter.sv
// Clear/enable up-counter over one temporal window; tc marks the enabled cycle
// that completes the W-th count.
module tlut_window_counter
   import tlut_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   output logic [DATA_WIDTH-1:0] cnt,
   output logic                  tc
);

   localparam int                    W        = window_len(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] LAST_VAL = DATA_WIDTH'(W - 1);

   logic [DATA_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state is updated only with non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = en && (cnt_q == LAST_VAL);

endmodule

// File: rtl/temporal_decoder.sv
// Temporal (unary/thermometer) stream to binary decoder: counts high cycles over
// a W-cycle window after start and hands the count out on a valid/ready port.
module temporal_decoder
   import tlut_pkg::*;
#(
   parameter int DATA_WIDTH   = 4,
   parameter bit CHECK_THERMO = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   temporal_decoder_if.master   dif
);

   dec_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] ones_q, ones_d;
   logic                  seen_zero_q, seen_zero_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_err_q, out_err_d;

   logic [DATA_WIDTH-1:0] ones_next;
   logic                  err_next;
   logic [DATA_WIDTH-1:0] cyc_cnt;
   logic                  cyc_tc;

   tlut_window_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cyc_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q != DEC_COUNT),
      .en    (state_q == DEC_COUNT),
      .cnt   (cyc_cnt),
      .tc    (cyc_tc)
   );

   always_comb begin
      ones_next   = ones_q + DATA_WIDTH'(dif.in_bit);
      // A one after any zero breaks the thermometer shape.
      err_next    = CHECK_THERMO ? (err_q | (seen_zero_q & dif.in_bit)) : 1'b0;

      state_d     = state_q;
      ones_d      = '0;
      seen_zero_d = 1'b0;
      err_d       = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;

      unique case (state_q)
         DEC_IDLE: begin
            if (dif.start) state_d = DEC_COUNT;
         end
         DEC_COUNT: begin
            ones_d      = ones_next;
            seen_zero_d = seen_zero_q | ~dif.in_bit;
            err_d       = err_next;
            if (cyc_tc) begin
               state_d     = DEC_HOLD;
               out_valid_d = 1'b1;
               out_data_d  = ones_next;
               out_err_d   = err_next;
            end
         end
         DEC_HOLD: begin
            if (dif.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = dif.start ? DEC_COUNT : DEC_IDLE;
            end
         end
         default: state_d = DEC_IDLE;
      endcase

      busy_d = (state_d != DEC_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DEC_IDLE;
         ones_q      <= '0;
         seen_zero_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ones_q      <= ones_d;
         seen_zero_q <= seen_zero_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   // The popcount can never exceed the number of cycles sampled so far.
   a_ones_le_cycles: assert property (@(posedge clk) disable iff (!rst_n) ones_q <= cyc_cnt);

   assign dif.busy      = busy_q;
   assign dif.out_valid = out_valid_q;
   assign dif.out_data  = out_data_q;
   assign dif.out_err   = out_err_q;

endmodule
